cmp_result_collector: RTL
=========================

Name: cmp_result_collector

Overview:
Downstream consumer of the 4-bit magnitude comparator (Comparator4Bit). It accepts one comparator result per handshake and keeps statistics over a measurement window: per-outcome counts, malformed-code count, running maximum of A, and an equal-streak alarm. A simple IDLE/COLLECT/DONE state machine frames the window so a test controller or board-level logic can read stable results.

Parameters:
W, 4, operand width of A/B (matches comparator).
CW, 8, width of each outcome counter (saturating).
STREAK, 3, consecutive EQ results that raise streak_alarm (legal range 2..2^CW-1).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  pulse; clear statistics and open window.
stop  input  1  pulse; close window, freeze results.
in_valid  input  1  A/B/R sample valid.
in_ready  output  1  collector can accept a sample.
A  input  W  operand A passed alongside result.
B  input  W  operand B (used only for err check).
R  input  3  comparator result {G,E,L}.
cnt_gt  output  CW  count of G results.
cnt_eq  output  CW  count of E results.
cnt_lt  output  CW  count of L results.
cnt_err  output  CW  count of malformed or inconsistent results.
max_a  output  W  largest A accepted in window.
streak_alarm  output  1  sticky; STREAK consecutive EQ seen.
busy  output  1  high in COLLECT.
done  output  1  high in DONE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all counters, max_a, streak counter = 0; streak_alarm, busy, done, in_ready = 0.
- States: IDLE -> COLLECT on start. COLLECT -> DONE on stop. DONE -> COLLECT on start. stop in IDLE/DONE ignored.
- start in any state: next cycle all counters, max_a, streak counter, streak_alarm cleared; state=COLLECT. start wins over stop when both high; a sample presented that same cycle is dropped.
- in_ready = 1 only in COLLECT (registered from state). Transfer = in_valid & in_ready at rising edge; results visible one cycle after transfer.
- Per transfer: R=100 -> cnt_gt+1; 010 -> cnt_eq+1; 001 -> cnt_lt+1; any other code -> cnt_err+1 only. Valid one-hot code inconsistent with A vs B (e.g. R=100 with A<=B) -> cnt_err+1 and outcome counter not incremented.
- All counters saturate at 2^CW-1; no wrap.
- max_a updated to A when transfer is accepted (any R) and A > max_a (unsigned).
- Streak: consecutive accepted EQ transfers increment streak counter; any non-EQ or erroneous transfer resets it to 0. Idle cycles (no transfer) do not break the streak. When count reaches STREAK, streak_alarm=1, sticky until start or reset.
- stop and transfer same cycle in COLLECT: sample is counted, then state=DONE.
- DONE: outputs frozen, in_ready=0, done=1.
- rst_n asserted mid-window: immediate clear to reset values regardless of state.

Test Plan:
- Reset: rst_n low mid-COLLECT with cnt_eq=5 -> all outputs 0 asynchronously, state IDLE, in_ready=0.
- Basic window: start; transfers (1,0,100),(2,3,001),(4,4,010),(7,6,100); stop -> cnt_gt=2, cnt_eq=1, cnt_lt=1, cnt_err=0, max_a=7, done=1.
- Errors: transfers R=011, R=000, (A=2,B=5,R=100) -> cnt_err=3, other counters 0, max_a=5? no: max_a=2 (A values only).
- Streak: EQ, EQ, idle 4 cycles, EQ -> streak_alarm=1 one cycle after 3rd EQ; EQ, GT, EQ, EQ sequence after restart -> alarm stays 0.
- Saturation: CW=8, 300 GT transfers -> cnt_gt=255, no wrap.
- Collisions: start+stop same cycle in DONE -> COLLECT with cleared stats; stop with transfer (10,10,010) -> cnt_eq incremented, done=1 next cycle.

Source files
------------

// File: rtl/cmp_result_collector_if.sv
// Sample handshake bundle between a comparator front end and the collector.
// The producer drives A/B/R with in_valid. The collector answers with in_ready.
interface cmp_result_collector_if #(
    parameter int W = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [2:0]   R;

    modport master (
        output in_valid,
        output A,
        output B,
        output R,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  A,
        input  B,
        input  R,
        output in_ready
    );
endinterface

// File: rtl/cmp_result_collector.sv
// Collects comparator results over a start/stop-framed measurement window.
// It keeps saturating per-outcome counts, an error count, the running maximum of A,
// and a sticky alarm for a run of consecutive equal results.
module cmp_result_collector #(
    parameter int W      = 4,
    parameter int CW     = 8,
    parameter int STREAK = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_start,
    input  logic          i_stop,
    cmp_result_collector_if.slave s_in,
    output logic [CW-1:0] o_cnt_gt,
    output logic [CW-1:0] o_cnt_eq,
    output logic [CW-1:0] o_cnt_lt,
    output logic [CW-1:0] o_cnt_err,
    output logic [W-1:0]  o_max_a,
    output logic          o_streak_alarm,
    output logic          o_busy,
    output logic          o_done
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0] STREAK_C = CW'(STREAK);

    // Counter step that holds at all-ones instead of wrapping.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        sat_inc = (v == CNT_MAX) ? v : v + {{(CW-1){1'b0}}, 1'b1};
    endfunction

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_in_ready;
    logic          r_busy;
    logic          r_done;
    logic [CW-1:0] r_cnt_gt;
    logic [CW-1:0] r_cnt_eq;
    logic [CW-1:0] r_cnt_lt;
    logic [CW-1:0] r_cnt_err;
    logic [W-1:0]  r_max_a;
    logic [CW-1:0] r_streak;
    logic          r_alarm;

    logic          w_xfer;
    logic          w_ok_gt;
    logic          w_ok_eq;
    logic          w_ok_lt;
    logic          w_ok_any;

    // A start pulse drops any sample offered in the same cycle.
    // A one-hot code counts as an outcome only if it agrees with A versus B.
    always_comb begin
        w_xfer   = s_in.in_valid & r_in_ready & ~i_start;
        w_ok_gt  = (s_in.R == 3'b100) & (s_in.A > s_in.B);
        w_ok_eq  = (s_in.R == 3'b010) & (s_in.A == s_in.B);
        w_ok_lt  = (s_in.R == 3'b001) & (s_in.A < s_in.B);
        w_ok_any = w_ok_gt | w_ok_eq | w_ok_lt;
    end

    // Window framing. Start has priority over stop. Stop is ignored outside COLLECT.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start) w_state_nxt = ST_COLLECT;
                else         w_state_nxt = ST_IDLE;
            end
            ST_COLLECT: begin
                if (i_start)     w_state_nxt = ST_COLLECT;
                else if (i_stop) w_state_nxt = ST_DONE;
                else             w_state_nxt = ST_COLLECT;
            end
            ST_DONE: begin
                if (i_start) w_state_nxt = ST_COLLECT;
                else         w_state_nxt = ST_DONE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register and the status flags registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt == ST_COLLECT);
            r_busy     <= (w_state_nxt == ST_COLLECT);
            r_done     <= (w_state_nxt == ST_DONE);
        end
    end

    // Window statistics. They clear on start and update once per accepted sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_gt  <= '0;
            r_cnt_eq  <= '0;
            r_cnt_lt  <= '0;
            r_cnt_err <= '0;
            r_max_a   <= '0;
            r_streak  <= '0;
            r_alarm   <= 1'b0;
        end else if (i_start) begin
            r_cnt_gt  <= '0;
            r_cnt_eq  <= '0;
            r_cnt_lt  <= '0;
            r_cnt_err <= '0;
            r_max_a   <= '0;
            r_streak  <= '0;
            r_alarm   <= 1'b0;
        end else if (w_xfer) begin
            if (w_ok_gt)   r_cnt_gt  <= sat_inc(r_cnt_gt);
            if (w_ok_eq)   r_cnt_eq  <= sat_inc(r_cnt_eq);
            if (w_ok_lt)   r_cnt_lt  <= sat_inc(r_cnt_lt);
            if (!w_ok_any) r_cnt_err <= sat_inc(r_cnt_err);
            if (s_in.A > r_max_a) r_max_a <= s_in.A;
            if (w_ok_eq) begin
                // The run length saturates at the threshold, which is all the alarm needs.
                if (r_streak < STREAK_C) r_streak <= r_streak + {{(CW-1){1'b0}}, 1'b1};
                if (r_streak >= STREAK_C - {{(CW-1){1'b0}}, 1'b1}) r_alarm <= 1'b1;
            end else begin
                r_streak <= '0;
            end
        end
    end

    assign s_in.in_ready  = r_in_ready;
    assign o_cnt_gt       = r_cnt_gt;
    assign o_cnt_eq       = r_cnt_eq;
    assign o_cnt_lt       = r_cnt_lt;
    assign o_cnt_err      = r_cnt_err;
    assign o_max_a        = r_max_a;
    assign o_streak_alarm = r_alarm;
    assign o_busy         = r_busy;
    assign o_done         = r_done;

endmodule
